video_fx_sharpen: RTL

//  Parametrised successor to the fixed edge-enhance stage between the pattern generator and vga2hdmi_ddr.
//  Per-pixel sharpen of 3 colour channels, selectable at run time:
//   - horizontal (3-tap)
//   - vertical (previous line from an internal line buffer)
//   - both
//   - bypass

---
 rtl/video_fx_sharpen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/video_fx_sharpen.sv
`default_nettype none
// ============================================================================
// Module   : video_fx_sharpen
// Purpose  : Run-time selectable H/V sharpen of an RGB pixel stream, 3 clk latency.
// Revision : 1.0
// ============================================================================
module video_fx_sharpen #(
  parameter int unsigned C_depth    = 8,
  parameter int unsigned C_line_max = 1024,
  parameter bit          C_vs_pol   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               in_blank,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic [C_depth-1:0] in_red,
  input  logic [C_depth-1:0] in_green,
  input  logic [C_depth-1:0] in_blue,
  output logic               out_blank,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic [C_depth-1:0] out_red,
  output logic [C_depth-1:0] out_green,
  output logic [C_depth-1:0] out_blue
);

  localparam int unsigned AW = $clog2(C_line_max);
  localparam int unsigned XW = AW + 1;
  localparam int unsigned SW = C_depth + 4;
  localparam int unsigned PW = 3 * C_depth;
  localparam logic [XW-1:0]        c_x_max   = XW'(C_line_max);
  localparam logic signed [SW-1:0] c_pix_max = SW'((1 << C_depth) - 1);

  logic [PW-1:0] s0_pix_q, s1_pix_q, s2_pix_q, out_pix_q;
  logic          s0_blank_q, s0_hs_q, s0_vs_q;
  logic          s1_blank_q, s1_hs_q, s1_vs_q;
  logic          s2_blank_q;
  logic          out_blank_q, out_hs_q, out_vs_q;
  logic [1:0]    mode_q;
  logic          first_line_q, wr_seen_q;
  logic [XW-1:0] x_q;
  logic [PW-1:0] line_mem [C_line_max];

  logic          w_frame_start, w_fall, w_first, w_in_range, w_we;
  logic [PW-1:0] w_up;
  wire  [PW-1:0] w_filt;

  assign w_frame_start = (in_vsync == C_vs_pol) && (s0_vs_q != C_vs_pol);
  assign w_fall        = !s1_blank_q && s2_blank_q;
  // The first pixel of the second line must already see the stored line.
  assign w_first       = first_line_q && !(wr_seen_q && w_fall);
  assign w_in_range    = (x_q < c_x_max);
  assign w_we          = !s1_blank_q && w_in_range;
  assign w_up          = line_mem[x_q[AW-1:0]];

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [C_depth-1:0]   w_c, w_l, w_r, w_u, w_o;
    logic signed [SW-1:0] w_cs, w_ls, w_rs, w_us, w_h, w_v, w_d, w_sum;

    always_comb begin
      w_c  = s1_pix_q[ch*C_depth +: C_depth];
      w_l  = s2_blank_q ? w_c : s2_pix_q[ch*C_depth +: C_depth];
      w_r  = s0_blank_q ? w_c : s0_pix_q[ch*C_depth +: C_depth];
      w_u  = (w_first || !w_in_range) ? w_c : w_up[ch*C_depth +: C_depth];
      w_cs = $signed({4'b0000, w_c});
      w_ls = $signed({4'b0000, w_l});
      w_rs = $signed({4'b0000, w_r});
      w_us = $signed({4'b0000, w_u});
      w_h  = (w_cs <<< 1) - w_ls - w_rs;
      w_v  = w_cs - w_us;
      case (mode_q)
        2'd0:    w_d = '0;
        2'd1:    w_d = w_h >>> 1;
        2'd2:    w_d = w_v;
        default: w_d = (w_h + (w_v <<< 1)) >>> 2;
      endcase
      w_sum = w_cs + w_d;
      if (w_sum < 0)              w_o = '0;
      else if (w_sum > c_pix_max) w_o = c_pix_max[C_depth-1:0];
      else                        w_o = w_sum[C_depth-1:0];
    end

    assign w_filt[ch*C_depth +: C_depth] = w_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_pix_q     <= '0;
      s1_pix_q     <= '0;
      s2_pix_q     <= '0;
      out_pix_q    <= '0;
      s0_blank_q   <= 1'b1;
      s1_blank_q   <= 1'b1;
      s2_blank_q   <= 1'b1;
      out_blank_q  <= 1'b1;
      s0_hs_q      <= 1'b0;
      s1_hs_q      <= 1'b0;
      out_hs_q     <= 1'b0;
      s0_vs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
      out_vs_q     <= 1'b0;
      mode_q       <= 2'd0;
      first_line_q <= 1'b1;
      wr_seen_q    <= 1'b0;
      x_q          <= '0;
    end else begin
      s0_pix_q    <= {in_red, in_green, in_blue};
      s0_blank_q  <= in_blank;
      s0_hs_q     <= in_hsync;
      s0_vs_q     <= in_vsync;
      s1_pix_q    <= s0_pix_q;
      s1_blank_q  <= s0_blank_q;
      s1_hs_q     <= s0_hs_q;
      s1_vs_q     <= s0_vs_q;
      s2_pix_q    <= s1_pix_q;
      s2_blank_q  <= s1_blank_q;
      out_pix_q   <= s1_blank_q ? '0 : w_filt;
      out_blank_q <= s1_blank_q;
      out_hs_q    <= s1_hs_q;
      out_vs_q    <= s1_vs_q;

      if (s1_blank_q)      x_q <= '0;
      else if (w_in_range) x_q <= x_q + XW'(1);

      if (w_frame_start) begin
        mode_q       <= mode;
        first_line_q <= 1'b1;
        wr_seen_q    <= 1'b0;
      end else begin
        if (w_we)                                       wr_seen_q    <= 1'b1;
        if (first_line_q && wr_seen_q && w_fall)        first_line_q <= 1'b0;
      end
    end
  end

  // Line RAM is deliberately not reset; first_line masks stale contents.
  always_ff @(posedge clk) begin
    if (w_we) line_mem[x_q[AW-1:0]] <= s1_pix_q;
  end

  assign out_blank = out_blank_q;
  assign out_hsync = out_hs_q;
  assign out_vsync = out_vs_q;
  assign out_red   = out_pix_q[3*C_depth-1 -: C_depth];
  assign out_green = out_pix_q[2*C_depth-1 -: C_depth];
  assign out_blue  = out_pix_q[C_depth-1:0];

endmodule
`default_nettype wire
